fifo_uart_tx: RTL and testbench

//  Read side of the sample FIFO: drains bytes with the FIFO's read_en pulse protocol.

---
 rtl/vib_uart_pkg.sv | 31 +++
 rtl/uart_baud_counter.sv | 49 ++++
 rtl/fifo_uart_tx.sv | 156 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vib_uart_pkg.sv
// ---------------------------------------------------------------------------
// vib_uart_pkg
// Shared definitions for the vibration-sample UART path (transmitter today,
// the matching receiver later).
//   state_t    : transmitter FSM state encoding (3 bits)
//   DATA_BITS  : payload bits per UART frame
//   clog2()    : elaboration-time ceil(log2), never narrower than 1 bit
// ---------------------------------------------------------------------------
package vib_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  // Counter widths derived from this must hold the value (value-1), so a
  // result of 0 is bumped to 1 to keep every counter at least one bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
// Bit-period timer shared by the UART transmitter and receiver. Counts
// 0..CLKS_PER_BIT-1 while run is high and wraps on its own, so consecutive
// bits are timed from a fresh zero and no error accumulates across a frame.
// Ports:
//   sys_clock  in  system clock
//   reset      in  asynchronous active-high reset
//   clear      in  synchronous clear to zero (has priority over run)
//   run        in  advance the count this cycle
//   last_tick  out high in the final cycle of a bit period
//   pre_tick   out high in the second-to-last cycle of a bit period, so a
//                  caller can register a flag that lines up with last_tick
// ---------------------------------------------------------------------------
module uart_baud_counter
  import vib_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic sys_clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic last_tick,
  output logic pre_tick
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written only with <= so every flop in the
  // design samples pre-edge values, independent of block ordering.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign last_tick = run && (cnt == CNT_LAST);
  assign pre_tick  = run && (cnt == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drains bytes from the sample FIFO (one-cycle read strobe, data valid
// RD_LATENCY cycles later) and sends each one as UART 8N1, LSB first.
// Keeps running while enable is high and the FIFO is non-empty; dropping
// enable lets the frame in flight finish before going idle.
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line rate in bit/s (CLK_HZ/BAUD, truncated, must be >= 2)
//   RD_LATENCY  cycles from the read-strobe cycle until fifo_dout is valid
// Ports:
//   sys_clock   in  system clock, all logic on the rising edge
//   reset       in  asynchronous active-high reset, clears all state
//   enable      in  permission to start new frames (sampled only in IDLE)
//   fifo_empty  in  FIFO empty flag (sampled only in IDLE)
//   fifo_dout   in  FIFO read data
//   fifo_rd_en  out one-cycle read strobe
//   tx          out serial line, idle high
//   busy        out high whenever the FSM is not in IDLE
//   byte_done   out one-cycle pulse in the last cycle of each stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx
  import vib_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int RD_LATENCY = 2
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 byte_done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int WAIT_W       = clog2(RD_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  state_t               state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;

  logic bit_phase;
  logic last_tick;
  logic pre_tick;

  // The baud timer only runs while a bit is on the line. Holding it clear
  // everywhere else, plus its own wrap on last_tick, means it is at zero on
  // entry to START, to each DATA bit and to STOP.
  assign bit_phase = (state == START) || (state == DATA) || (state == STOP);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .sys_clock (sys_clock),
    .reset     (reset),
    .clear     (!bit_phase),
    .run       (bit_phase),
    .last_tick (last_tick),
    .pre_tick  (pre_tick)
  );

  // Every output is a flop written alongside the state change that implies
  // it, so tx/busy/fifo_rd_en switch in the same cycle the new state begins.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      wait_cnt   <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end

        // The strobe lasts exactly this one cycle, giving the FIFO a single
        // falling edge per byte.
        FETCH: begin
          fifo_rd_en <= 1'b0;
          wait_cnt   <= '0;
          state      <= WAIT;
        end

        // The byte is committed once the strobe has fired; fifo_empty is not
        // looked at again until the next IDLE.
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            shreg <= fifo_dout;
            tx    <= 1'b0;
            state <= START;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        START: begin
          if (last_tick) begin
            tx      <= shreg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end

        // tx is loaded with the bit that will be in shreg[0] after the shift.
        DATA: begin
          if (last_tick) begin
            shreg <= shreg >> 1;
            if (bit_idx == LAST_BIT) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        // pre_tick one cycle early lands the registered pulse on the final
        // stop-bit cycle.
        STOP: begin
          byte_done <= pre_tick;
          if (last_tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          tx         <= 1'b1;
          fifo_rd_en <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Bench for fifo_uart_tx at CLKS_PER_BIT=10, RD_LATENCY=2. A small FIFO
// model answers the read strobe, a frame-level reference model predicts the
// four outputs every cycle, and directed scenarios add literal frame checks.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int L      = 2;
  localparam int CPB    = 10;
  localparam int FRAME  = 10 * CPB;

  logic       sys_clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       byte_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clock = ~sys_clock;

  fifo_uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .RD_LATENCY (L)
  ) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .byte_done  (byte_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       hold_full = 1'b0;
  logic       force_empty = 1'b0;
  logic [7:0] pend = 8'h00;
  int         dly = 0;
  int         n_rd = 0;
  int         n_done = 0;

  assign fifo_empty = force_empty | (!hold_full & (wr_ptr == rd_ptr));

  // Data appears mid-cycle of the L-th cycle after the strobe cycle.
  always @(negedge sys_clock) begin
    if (dly > 0) begin
      dly--;
      if (dly == 0) fifo_dout = pend;
    end
    if (fifo_rd_en) begin
      pend = mem[rd_ptr % 64];
      if (wr_ptr != rd_ptr) rd_ptr++;
      n_rd++;
      dly = L;
    end
    if (byte_done) n_done++;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  // ---------------- reference model ----------------
  // m_t counts cycles since the start decision: 0 = strobe, 1..L = wait,
  // then a 100-cycle frame.
  bit         m_active = 0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge sys_clock) begin
    if (reset) begin
      m_active = 0;
    end else if (!m_active) begin
      if (enable && !fifo_empty) begin
        m_active = 1;
        m_t      = 0;
        m_byte   = mem[rd_ptr % 64];
      end
    end else begin
      m_t++;
      if (m_t > L + FRAME) m_active = 0;
    end
  end

  // Returns {tx, fifo_rd_en, busy, byte_done}.
  function automatic logic [3:0] model_out();
    int f;
    if (reset || !m_active) return 4'b1000;
    if (m_t == 0) return 4'b1110;
    if (m_t <= L) return 4'b1010;
    f = m_t - L - 1;
    if (f < CPB) return 4'b0010;
    if (f < 9 * CPB) return {m_byte[(f - CPB) / CPB], 3'b010};
    return {3'b101, (f == FRAME - 1)};
  endfunction

  always @(negedge sys_clock) begin
    check("cycle {tx,rd_en,busy,byte_done}", {28'b0, tx, fifo_rd_en, busy, byte_done},
          {28'b0, model_out()});
  end

  // ---------------- helpers ----------------
  // Waits for a start bit, samples each bit mid-period into bits[0..9]
  // (start first), and measures cycles from first tx=0 through byte_done.
  task automatic capture(input int drop_at, output logic [9:0] bits, output int len,
                         output int pre_high);
    bit seen;
    bits = '0; len = 0; pre_high = 0; seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clock);
      if (tx == 1'b0) begin
        seen = 1;
        break;
      end
      pre_high++;
    end
    if (!seen) begin
      check("start bit seen", 0, 1);
      return;
    end
    for (int c = 0; c < 150; c++) begin
      if (c > 0) @(negedge sys_clock);
      if (c == drop_at) begin
        #1 enable = 1'b0;
      end
      if ((c % CPB) == CPB / 2 && c < 10 * CPB) bits[c / CPB] = tx;
      if (byte_done) begin
        len = c + 1;
        break;
      end
    end
  endtask

  task automatic wait_rd();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clock);
      if (fifo_rd_en) begin
        seen = 1;
        break;
      end
    end
    check("rd_en seen", 32'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    logic [9:0] bits;
    int len, pre, base_rd, base_done;

    reset = 1'b1; enable = 1'b1; hold_full = 1'b1;

    // 1: reset held with a non-empty FIFO, then idle with an empty FIFO
    repeat (3) @(negedge sys_clock);
    check("reset tx", 32'(tx), 1);
    check("reset rd_en", 32'(fifo_rd_en), 0);
    check("reset busy", 32'(busy), 0);
    #1 hold_full = 1'b0;
    #1 reset = 1'b0;
    base_rd = n_rd;
    repeat (200) @(negedge sys_clock);
    check("no rd_en while empty", 32'(n_rd - base_rd), 0);
    check("idle busy", 32'(busy), 0);

    // 2: single byte 0xA5
    #1 push(8'hA5);
    base_rd = n_rd; base_done = n_done;
    capture(-1, bits, len, pre);
    check("frame A5 bits", 32'(bits), 32'h34A);
    check("frame A5 length", 32'(len), 100);
    repeat (10) @(negedge sys_clock);
    check("A5 rd_en pulses", 32'(n_rd - base_rd), 1);
    check("A5 byte_done pulses", 32'(n_done - base_done), 1);

    // 3: back-to-back 0x00, 0xFF
    #1 push(8'h00); push(8'hFF);
    base_rd = n_rd;
    capture(-1, bits, len, pre);
    check("frame 00 bits", 32'(bits), 32'h200);
    check("frame 00 length", 32'(len), 100);
    capture(-1, bits, len, pre);
    check("frame FF bits", 32'(bits), 32'h3FE);
    check("inter-frame idle cycles", 32'(pre), 4);
    repeat (10) @(negedge sys_clock);
    check("00/FF rd_en pulses", 32'(n_rd - base_rd), 2);

    // 4: reset during DATA bit 3 of 0x0F, then 0x66 goes out cleanly
    #1 push(8'h0F); push(8'h66);
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clock);
      if (tx == 1'b0) break;
    end
    repeat (CPB + 3 * CPB + 5) @(negedge sys_clock);
    check("busy before abort", 32'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("abort tx", 32'(tx), 1);
    check("abort busy", 32'(busy), 0);
    check("abort byte_done", 32'(byte_done), 0);
    repeat (3) @(negedge sys_clock);
    #1 reset = 1'b0;
    capture(-1, bits, len, pre);
    check("frame 66 bits", 32'(bits), 32'h2CC);
    check("frame 66 length", 32'(len), 100);

    // 5: enable dropped during START of 0x3C with 0x11 queued
    repeat (5) @(negedge sys_clock);
    #1 push(8'h3C); push(8'h11);
    base_rd = n_rd;
    capture(3, bits, len, pre);
    check("frame 3C bits", 32'(bits), 32'h278);
    check("frame 3C length", 32'(len), 100);
    repeat (50) @(negedge sys_clock);
    check("no rd_en while disabled", 32'(n_rd - base_rd), 1);
    check("disabled busy", 32'(busy), 0);
    #1 enable = 1'b1;
    capture(-1, bits, len, pre);
    check("frame 11 bits", 32'(bits), 32'h222);

    // 6: FIFO reports empty during WAIT
    repeat (5) @(negedge sys_clock);
    #1 push(8'h81); push(8'h42);
    base_rd = n_rd;
    wait_rd();
    @(negedge sys_clock);
    #1 force_empty = 1'b1;
    capture(-1, bits, len, pre);
    check("frame 81 bits", 32'(bits), 32'h302);
    repeat (30) @(negedge sys_clock);
    check("no rd_en while flagged empty", 32'(n_rd - base_rd), 1);
    #1 force_empty = 1'b0;
    capture(-1, bits, len, pre);
    check("frame 42 bits", 32'(bits), 32'h284);
    repeat (10) @(negedge sys_clock);
    check("81/42 rd_en pulses", 32'(n_rd - base_rd), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
